// File: rtl/dmem_burst_initiator.sv
// ---------------------------------------------------------------------------
// dmem_burst_initiator
//
// Initiator-side burst engine for the data memory port. One accepted request
// becomes a sequence of single-word reads or writes on the memory interface
// (cs/oe/we/addr/din/dout). Read beats are returned on a valid/ready stream
// and write beats are pulled from a valid/ready stream. The request is
// checked for alignment and address range before any memory cycle is issued.
// Completion (or rejection) is reported with a one-cycle done pulse and err.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      burst request handshake
//   req_we, req_addr, req_len  direction, start byte address, beats minus one
//   wr_valid/wr_ready/wr_data  write data stream (engine is the sink)
//   rd_valid/rd_ready/rd_data/rd_last  read data stream (engine is the source)
//   done, err                end-of-burst pulse and rejection flag
//   cs, oe, we, addr, din    registered memory-side controls
//   dout                     memory read data
// ---------------------------------------------------------------------------
module dmem_burst_initiator #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned RD_LAT    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        err,
    output logic        cs,
    output logic        oe,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] din,
    input  logic [31:0] dout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        RD_ADDR  = 3'd2,
        RD_HOLD  = 3'd3,
        WR_WAIT  = 3'd4,
        WR_DRIVE = 3'd5,
        FIN      = 3'd6
    } state_t;

    // One byte past the last word of data memory, in 34 bits so the
    // end-of-burst comparison can never wrap.
    localparam logic [33:0] MEM_END  = {2'b00, BASE_ADDR} + (34'(MEM_WORDS) << 2);
    // Value of the hold counter on the cycle dout is sampled.
    localparam logic [1:0]  LAT_LAST = 2'(RD_LAT);

    // A request is rejected if misaligned, below the memory base, or if
    // its last byte would fall past the end of memory.
    function automatic logic range_bad(input logic [31:0] start, input logic [7:0] len);
        logic [33:0] burst_bytes;
        logic [33:0] burst_end;
        burst_bytes = ({26'd0, len} + 34'd1) << 2;
        burst_end   = {2'b00, start} + burst_bytes;
        return (start[1:0] != 2'b00) || (start < BASE_ADDR) || (burst_end > MEM_END);
    endfunction

    state_t      state_r, state_s;
    logic        is_wr_r, is_wr_s;
    logic [31:0] cur_r, cur_s;
    logic [7:0]  len_r, len_s;
    logic [7:0]  beat_r, beat_s;
    logic [1:0]  lat_r, lat_s;

    logic        cs_r, cs_s;
    logic        oe_r, oe_s;
    logic        we_r, we_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] din_r, din_s;
    logic        rd_valid_r, rd_valid_s;
    logic [31:0] rd_data_r, rd_data_s;
    logic        rd_last_r, rd_last_s;
    logic        done_r, done_s;
    logic        err_r, err_s;

    logic        last_beat_s;
    logic        bad_s;

    // Burst bookkeeping decoded from the captured request.
    always_comb begin
        last_beat_s = (beat_r == len_r);
        bad_s       = range_bad(cur_r, len_r);
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            is_wr_r    <= 1'b0;
            cur_r      <= 32'd0;
            len_r      <= 8'd0;
            beat_r     <= 8'd0;
            lat_r      <= 2'd0;
            cs_r       <= 1'b0;
            oe_r       <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= 32'd0;
            din_r      <= 32'd0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 32'd0;
            rd_last_r  <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            is_wr_r    <= is_wr_s;
            cur_r      <= cur_s;
            len_r      <= len_s;
            beat_r     <= beat_s;
            lat_r      <= lat_s;
            cs_r       <= cs_s;
            oe_r       <= oe_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            din_r      <= din_s;
            rd_valid_r <= rd_valid_s;
            rd_data_r  <= rd_data_s;
            rd_last_r  <= rd_last_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    // Next-state and next-output decode. Memory controls and pulses default
    // to 0 so every state only names what it drives; the next-state values of
    // the memory controls are what appear on the pins during that state.
    always_comb begin
        state_s    = state_r;
        is_wr_s    = is_wr_r;
        cur_s      = cur_r;
        len_s      = len_r;
        beat_s     = beat_r;
        lat_s      = lat_r;
        cs_s       = 1'b0;
        oe_s       = 1'b0;
        we_s       = 1'b0;
        addr_s     = 32'd0;
        din_s      = 32'd0;
        rd_valid_s = 1'b0;
        rd_data_s  = rd_data_r;
        rd_last_s  = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    is_wr_s = req_we;
                    cur_s   = req_addr;
                    len_s   = req_len;
                    beat_s  = 8'd0;
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end

            CHECK: begin
                if (bad_s) begin
                    // Rejected before any chip select; report on the way out.
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                    state_s = FIN;
                end else if (is_wr_r) begin
                    state_s = WR_WAIT;
                end else begin
                    cs_s    = 1'b1;
                    oe_s    = 1'b1;
                    addr_s  = cur_r;
                    lat_s   = 2'd0;
                    state_s = RD_ADDR;
                end
            end

            RD_ADDR: begin
                if (lat_r == LAT_LAST) begin
                    // Address has been held long enough: capture the word.
                    rd_data_s  = dout;
                    rd_valid_s = 1'b1;
                    rd_last_s  = last_beat_s;
                    state_s    = RD_HOLD;
                end else begin
                    lat_s  = lat_r + 2'd1;
                    cs_s   = 1'b1;
                    oe_s   = 1'b1;
                    addr_s = cur_r;
                end
            end

            RD_HOLD: begin
                if (rd_ready) begin
                    if (last_beat_s) begin
                        done_s  = 1'b1;
                        state_s = FIN;
                    end else begin
                        cur_s   = cur_r + 32'd4;
                        beat_s  = beat_r + 8'd1;
                        cs_s    = 1'b1;
                        oe_s    = 1'b1;
                        addr_s  = cur_r + 32'd4;
                        lat_s   = 2'd0;
                        state_s = RD_ADDR;
                    end
                end else begin
                    // Consumer stalled: keep the beat presented unchanged.
                    rd_valid_s = 1'b1;
                    rd_last_s  = rd_last_r;
                end
            end

            WR_WAIT: begin
                if (wr_valid) begin
                    cs_s    = 1'b1;
                    we_s    = 1'b1;
                    addr_s  = cur_r;
                    din_s   = wr_data;
                    state_s = WR_DRIVE;
                end else begin
                    state_s = WR_WAIT;
                end
            end

            WR_DRIVE: begin
                // Memory commits on the edge that leaves this state.
                if (last_beat_s) begin
                    done_s  = 1'b1;
                    state_s = FIN;
                end else begin
                    cur_s   = cur_r + 32'd4;
                    beat_s  = beat_r + 8'd1;
                    state_s = WR_WAIT;
                end
            end

            FIN: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Handshake readiness is a pure decode of the current state. The request
    // side is also held off while reset is applied so every output reads 0.
    always_comb begin
        req_ready = (state_r == IDLE) && !rst;
        wr_ready  = (state_r == WR_WAIT);
    end

    assign cs       = cs_r;
    assign oe       = oe_r;
    assign we       = we_r;
    assign addr     = addr_r;
    assign din      = din_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign rd_last  = rd_last_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_dmem_burst_initiator.sv
// ---------------------------------------------------------------------------
// Self-checking bench for dmem_burst_initiator. A behavioural data memory is
// attached to the memory port; a separate reference image of memory is kept
// and updated burst by burst from the request alone.
// ---------------------------------------------------------------------------
module tb_dmem_burst_initiator;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          WORDS = 1024;
    localparam int          LAT   = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done, err, cs, oe, we;
    logic [31:0] addr, din, dout;

    always #5 clk = ~clk;

    dmem_burst_initiator #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .cs(cs), .oe(oe), .we(we), .addr(addr), .din(din), .dout(dout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[11:2]);
    endfunction

    // Reference rule for rejection, straight from the address arithmetic.
    function automatic logic exp_err_of(input logic [31:0] a, input int l);
        longint last_end;
        last_end = longint'(a) + 4 * (longint'(l) + 1);
        return (a[1:0] != 2'b00) || (a < BASE) || (last_end > longint'(BASE) + 4 * WORDS);
    endfunction

    // Behavioural data memory.
    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic [31:0] wdat    [0:255];
    logic        load_mem;

    assign dout = (cs && oe) ? mem[widx(addr)] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_val(i);
        end else if (cs && we) begin
            mem[widx(addr)] <= din;
        end
    end

    // Bus monitor.
    int          cs_cnt = 0, rdm_cnt = 0, done_cnt = 0, viol = 0, stab_viol = 0;
    logic        last_err = 1'b0;
    logic [32:0] rlog  [$];
    logic [31:0] raddr [$];
    logic [63:0] wlog  [$];
    logic        hold_prev = 1'b0;
    logic [31:0] hold_data = 32'd0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cs) cs_cnt++;
            if (cs && oe) begin rdm_cnt++; raddr.push_back(addr); end
            if (cs && we) wlog.push_back({addr, din});
            if (rd_valid && rd_ready) rlog.push_back({rd_last, rd_data});
            if (done) begin done_cnt++; last_err = err; end
            if (we && oe) viol++;
            if (cs && (addr < BASE || addr >= BASE + 32'(WORDS * 4))) viol++;
            if (wr_ready && (cs || rd_valid)) viol++;
            if (req_ready && (cs || rd_valid || wr_ready)) viol++;
            if (err && !done) viol++;
            if (hold_prev && (!rd_valid || rd_data != hold_data)) stab_viol++;
            hold_prev = rd_valid && !rd_ready;
            hold_data = rd_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic issue_req(input logic w, input logic [31:0] a, input int l);
        logic acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_we    = w;
        req_addr  = a;
        req_len   = 8'(l);
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("req_accept", longint'(acc), 1);
    endtask

    task automatic run_burst(input logic w, input logic [31:0] a, input int l,
                             input logic exp_err, input int gap, input int stall_at,
                             input logic rnd);
        int   cb, rb, ab, wb, db, rmb, wi, cyc;
        logic fin;
        cb = cs_cnt; rb = rlog.size(); ab = raddr.size(); wb = wlog.size();
        db = done_cnt; rmb = rdm_cnt;
        issue_req(w, a, l);
        wi = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 3000) begin
            wr_valid = w && (wi <= l) && (rnd ? ($urandom_range(0, 1) == 1) : (gap == 0 || cyc % 2 == 0));
            wr_data  = wr_valid ? wdat[8'(wi)] : 32'd0;
            rd_ready = !w && (rnd ? ($urandom_range(0, 3) != 0)
                                  : !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5));
            @(negedge clk);
            if (wr_valid && wr_ready) wi++;
            fin = done;
            @(posedge clk); #1;
            cyc++;
        end
        wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0;
        chk("done_seen", longint'(fin), 1);
        chk("done_count", done_cnt - db, 1);
        chk("err_flag", longint'(last_err), longint'(exp_err));
        chk("req_ready_after", longint'(req_ready), 1);
        if (exp_err) begin
            chk("no_cs_on_err", cs_cnt - cb, 0);
        end else if (w) begin
            chk("wr_pulses", wlog.size() - wb, l + 1);
            for (int k = 0; k <= l && wb + k < wlog.size(); k++) begin
                chk("wr_addr", longint'(wlog[wb + k][63:32]), longint'(a + 32'(4 * k)));
                chk("wr_data", longint'(wlog[wb + k][31:0]), longint'(wdat[k]));
            end
            for (int k = 0; k <= l; k++) begin
                ref_mem[widx(a) + k] = wdat[k];
                chk("mem_word", longint'(mem[widx(a) + k]), longint'(wdat[k]));
            end
        end else begin
            chk("rd_beats", rlog.size() - rb, l + 1);
            chk("rd_mem_cycles", rdm_cnt - rmb, (l + 1) * (LAT + 1));
            for (int k = 0; k <= l && rb + k < rlog.size(); k++) begin
                chk("rd_data", longint'(rlog[rb + k][31:0]), longint'(ref_mem[widx(a) + k]));
                chk("rd_last", longint'(rlog[rb + k][32]), (k == l) ? 1 : 0);
            end
            for (int k = 0; k <= l && ab + k * (LAT + 1) < raddr.size(); k++)
                chk("rd_addr", longint'(raddr[ab + k * (LAT + 1)]), longint'(a + 32'(4 * k)));
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        int          l;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int   wb, db, wi;
        logic hit;
        logic [31:0] ra;
        int   rl, kind;

        vecs[0]  = '{1'b0, 32'h1000_000C,   2, 1'b0};
        vecs[1]  = '{1'b1, 32'h1000_0024,   1, 1'b0};
        vecs[2]  = '{1'b0, 32'h1000_0024,   1, 1'b0};
        vecs[3]  = '{1'b0, 32'h1000_0026,   0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0FFF_FFFC,   0, 1'b1};
        vecs[5]  = '{1'b0, 32'h1000_0FF0,   4, 1'b1};
        vecs[6]  = '{1'b0, 32'h1000_0FF0,   3, 1'b0};
        vecs[7]  = '{1'b1, 32'h1000_0FFC,   0, 1'b0};
        vecs[8]  = '{1'b0, 32'h1000_0C00, 255, 1'b0};
        vecs[9]  = '{1'b0, 32'h1000_0C04, 255, 1'b1};
        vecs[10] = '{1'b1, 32'h1000_0001,   0, 1'b1};
        vecs[11] = '{1'b1, 32'h1000_0FF0,   4, 1'b1};
        vecs[12] = '{1'b0, 32'h1000_0000,   0, 1'b0};

        rst = 1'b1; load_mem = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_len = 8'd0;
        wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 256; i++) wdat[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", longint'({req_ready, wr_ready, rd_valid, rd_last, done, err, cs, oe, we}), 0);
        chk("reset_addr", longint'(addr), 0);
        chk("reset_din", longint'(din), 0);
        chk("reset_rd_data", longint'(rd_data), 0);
        load_mem = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_req_ready", longint'(req_ready), 1);

        // Directed table.
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].w)
                for (int k = 0; k <= vecs[v].l; k++)
                    wdat[k] = 32'h0000_FF00 | ((vecs[v].a + 32'(4 * k)) & 32'h0000_00FF);
            run_burst(vecs[v].w, vecs[v].a, vecs[v].l, vecs[v].exp_err, 0, -1, 1'b0);
        end

        // Consumer stalls 5 cycles in the middle of a 4-beat read.
        run_burst(1'b0, BASE + 32'h100, 3, 1'b0, 0, 4, 1'b0);
        chk("stall_stable", stab_viol, 0);

        // Write burst with data offered every other cycle.
        for (int k = 0; k < 4; k++) wdat[k] = 32'hA000_0000 + 32'(k * 17);
        run_burst(1'b1, BASE + 32'h200, 3, 1'b0, 1, -1, 1'b0);

        // Reset during the write cycle of beat 2 of 4.
        for (int k = 0; k < 4; k++) wdat[k] = 32'hC0DE_0000 | 32'(k);
        wb = wlog.size(); db = done_cnt;
        issue_req(1'b1, BASE + 32'h300, 3);
        wi = 0; hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            wr_valid = (wi <= 3);
            wr_data  = wdat[8'(wi)];
            @(negedge clk); #1;
            if (wr_valid && wr_ready) wi++;
            if (wlog.size() - wb == 2) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("rst_reached_beat2", longint'(hit), 1);
        rst = 1'b1; wr_valid = 1'b0; wr_data = 32'd0;
        @(posedge clk); #1;
        chk("rst_mid_ctrl", longint'({req_ready, wr_ready, rd_valid, rd_last, done, err, cs, oe, we}), 0);
        chk("rst_mid_addr", longint'(addr), 0);
        chk("rst_mid_din", longint'(din), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - db, 0);
        for (int k = 0; k < 4; k++)
            chk("rst_mem", longint'(mem[widx(BASE + 32'h300) + k]),
                longint'((k < 2) ? wdat[k] : ref_mem[widx(BASE + 32'h300) + k]));
        ref_mem[widx(BASE + 32'h300)]     = wdat[0];
        ref_mem[widx(BASE + 32'h300) + 1] = wdat[1];
        run_burst(1'b0, BASE + 32'h300, 3, 1'b0, 0, -1, 1'b0);

        // Randomized bursts against the reference image.
        for (int n = 0; n < 30; n++) begin
            rl   = $urandom_range(0, 15);
            kind = $urandom_range(0, 9);
            case (kind)
                0:       ra = BASE + 32'(4 * $urandom_range(0, 1000)) + 32'($urandom_range(1, 3));
                1:       ra = BASE - 32'(4 * $urandom_range(1, 8));
                2:       ra = BASE + 32'(4 * (WORDS - $urandom_range(1, 16)));
                default: ra = BASE + 32'(4 * $urandom_range(0, WORDS - 1 - rl));
            endcase
            for (int k = 0; k <= rl; k++) wdat[k] = $urandom;
            run_burst(1'($urandom_range(0, 1)), ra, rl, exp_err_of(ra, rl), 0, -1, 1'b1);
        end

        chk("bus_rules", viol, 0);
        chk("hold_stable", stab_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_burst_initiator.md
Name: dmem_burst_initiator

Overview:
- Initiator-side engine for the data memory port (cs/oe/we/addr/din/dout). It turns one burst request from the core or a DMA client into a sequence of word reads or writes against the data memory.
- Read data is returned on a handshaked stream. Write data is pulled from a handshaked stream.
- Checks alignment and address range before any memory activity, and reports completion or error with a one-cycle done pulse.
- Sits between the load/store path and data memory. It is the master of the same interface the memory responds on.

Parameters:
BASE_ADDR, 32'h10000000, byte address of data memory word 0
MEM_WORDS, 1024, number of 32-bit words in data memory
RD_LAT, 0, extra cycles address is held before dout is sampled (legal 0..3)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  burst request valid
req_ready  out  1  engine idle and able to accept
req_we  in  1  1 = write burst, 0 = read burst
req_addr  in  32  start byte address
req_len  in  8  beats minus one (0 = 1 word, 255 = 256 words)
wr_valid  in  1  write data beat valid
wr_ready  out  1  engine takes wr_data this cycle
wr_data  in  32  write data beat
rd_valid  out  1  read data beat valid
rd_ready  in  1  consumer accepts rd_data
rd_data  out  32  read data beat
rd_last  out  1  marks final read beat
done  out  1  one-cycle pulse at burst end
err  out  1  valid with done: 1 = request rejected
cs  out  1  memory chip select
oe  out  1  memory output enable
we  out  1  memory write enable
addr  out  32  memory byte address
din  out  32  memory write data
dout  in  32  memory read data

Behaviour:
- Reset and outputs
  - One clock (clk); reset rst is synchronous and active-high.
  - On reset, every output is 0 and the state is IDLE.
  - Memory-side outputs (cs, oe, we, addr, din) are registered.
  - The handshake outputs req_ready and wr_ready are decoded from state.
- States: IDLE, CHECK, RD_ADDR, RD_HOLD, WR_WAIT, WR_DRIVE, FIN.
- IDLE
  - req_ready=1. Memory outputs are all 0.
  - On req_valid && req_ready: capture we, addr, len; set beat counter=0; go to CHECK.
- CHECK (1 cycle)
  - err condition: addr[1:0]!=0, or addr<BASE_ADDR, or addr+4*(len+1) > BASE_ADDR+4*MEM_WORDS.
  - Evaluate the sum in 34 bits so it cannot wrap.
  - On error: go to FIN with err latched. No cs assertion ever occurs.
  - Otherwise: go to RD_ADDR (read) or WR_WAIT (write).
- RD_ADDR
  - Drive cs=1, oe=1, we=0, addr=cur for RD_LAT+1 cycles.
  - At the final edge, register dout into rd_data.
  - Set rd_valid=1, and rd_last=1 if this is the last beat. Go to RD_HOLD.
- RD_HOLD
  - rd_valid and rd_data are held stable until rd_ready.
  - cs and oe are 0 while holding.
  - On handshake: if last beat, go to FIN; else cur+=4, beat counter+=1, return to RD_ADDR.
  - rd_valid drops the cycle after the handshake.
- WR_WAIT
  - wr_ready=1. Memory outputs are 0.
  - On wr_valid: register cs=1, we=1, oe=0, addr=cur, din=wr_data. Go to WR_DRIVE.
- WR_DRIVE (exactly 1 cycle)
  - we is high for exactly one clock edge, which is where memory commits the write.
  - Next: deassert cs/we. If last beat, go to FIN; else cur+=4, return to WR_WAIT.
- FIN: done=1 for one cycle, err as latched. Return to IDLE (req_ready=1 the following cycle).
- Throughput and latency
  - Write beat: 2 cycles minimum.
  - Read beat: RD_LAT+2 cycles minimum plus consumer stall.
  - A request accepted at edge N reaches CHECK at N+1.
- Constraints and corner cases
  - we and oe are never both 1.
  - addr never leaves the range checked in CHECK.
  - req_len=255 at the top of memory is legal if it fits exactly; one word more is an error.
  - Reset mid-burst:
    - A write already registered in WR_DRIVE completes at that edge.
    - All outputs are 0 the cycle after the reset edge.
    - No done pulse is produced.
    - Partially written data is not rolled back.
  - req_valid is ignored outside IDLE. wr_valid is ignored outside WR_WAIT.

Test Plan:
- Reset, then read 3 words from 32'h1000000c with RD_LAT=0 and rd_ready=1:
  - addr steps 0c/10/14.
  - rd_data matches the memory file.
  - rd_last only on the 3rd beat; one done with err=0.
- Write 2 words at 32'h10000024 with data 0000FF24/0000FF28:
  - we pulses exactly 2 single cycles with addr 24 then 28.
  - A read-back burst returns FF24, FF28.
- Misaligned 32'h10000026, and 32'h0FFFFFFC, and top-of-memory overrun (BASE+4*1020, len=4):
  - done with err=1 each time; cs never asserted.
  - len=3 at the same address succeeds.
- Read with rd_ready low for 5 cycles mid-burst:
  - rd_data and rd_valid stable throughout; no extra memory reads; no beat lost.
- Write burst len=3 with wr_valid gapped every other cycle:
  - 4 writes in order; wr_ready only in WR_WAIT.
- Assert rst during the WR_DRIVE of beat 2 of 4:
  - Beat 2 committed, beats 3-4 not.
  - All outputs 0 next cycle; no done; a new request is accepted afterwards.
